// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode constant
// and the request-length width helper.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00; // {CPOL, CPHA}

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SETUP    = 3'd1;
  localparam state_t ST_SHIFT_HI = 3'd2;
  localparam state_t ST_SHIFT_LO = 3'd3;
  localparam state_t ST_HOLD     = 3'd4;
  localparam state_t ST_RESP     = 3'd5;

  function automatic int LEN_W(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response channel of the SPI master: valid/ready request in,
// valid/ready received-data response out.
interface spi_master_if #(
  parameter int DATA_W = 64,
  parameter int SS_W   = 8
) ();

  logic                                 req_valid;
  logic                                 req_ready;
  logic [DATA_W-1:0]                    req_tx;
  logic [spi_pkg::LEN_W(DATA_W)-1:0]    req_len;
  logic [SS_W-1:0]                      req_ss;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [DATA_W-1:0]                    rsp_rx;

  modport master (
    output req_valid, req_tx, req_len, req_ss, rsp_ready,
    input  req_ready, rsp_valid, rsp_rx
  );

  modport slave (
    input  req_valid, req_tx, req_len, req_ss, rsp_ready,
    output req_ready, rsp_valid, rsp_rx
  );

endinterface

// File: rtl/spi_master_clkgen.sv
// Half-period divider for sck: counts 0..DIV-1 while enabled and emits one-cycle
// rise/fall pulses on the cycle whose closing edge toggles sck.
module spi_clkgen #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic allow_rise_i,
  output logic tick_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o,
  output logic sck_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          sck_q, sck_d;

  assign tick_o       = en_i && (div_q == LAST);
  assign rise_pulse_o = tick_o && !sck_q && allow_rise_i;
  assign fall_pulse_o = tick_o && sck_q;
  assign sck_o        = sck_q;

  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    div_d = div_q;
    sck_d = sck_q;
    if (!en_i || tick_o) div_d = '0;
    else                 div_d = div_q + CW'(1);
    if (!en_i)                             sck_d = 1'b0;
    else if (rise_pulse_o || fall_pulse_o) sck_d = !sck_q;
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking so each flop samples the pre-edge value of every other flop.
    if (reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, one transfer of up to DATA_W bits per request, MSB first.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first (result stays right-aligned).
module spi_master import spi_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int SS_W   = 8,
  parameter int DIV    = 4
) (
  input  logic            clock,
  input  logic            reset,
  spi_master_if.slave     bus,
  output logic            sck,
  output logic [SS_W-1:0] ss,
  output logic            mosi,
  input  logic            miso
);

  localparam int            LW      = LEN_W(DATA_W);
  localparam logic [LW-1:0] LEN_MAX = LW'(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [LW-1:0]     bit_cnt_q, bit_cnt_d, req_len_c;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              accept, in_xfer, allow_rise, req_ready_c;
  logic              tick, rise_pulse, fall_pulse, sck_int;

  assign req_len_c = (bus.req_len > LEN_MAX) ? LEN_MAX : bus.req_len;
  assign accept    = bus.req_valid && (state_q == ST_IDLE);

  spi_clkgen #(.DIV(DIV)) u_clkgen (
    .clock        (clock),
    .reset        (reset),
    .en_i         (in_xfer),
    .allow_rise_i (allow_rise),
    .tick_o       (tick),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse),
    .sck_o        (sck_int)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = (req_len_c == '0) ? ST_RESP : ST_SETUP;
      ST_SETUP:    if (rise_pulse) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (fall_pulse) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (rise_pulse) state_d = ST_SHIFT_HI;
                   else if (tick)  state_d = ST_HOLD;
      ST_HOLD:     if (tick) state_d = ST_RESP;
      ST_RESP:     if (rsp_valid_q && bus.rsp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // The outgoing bit always sits at one fixed end of tx_q.
  always_comb begin
    in_xfer     = (state_q == ST_SETUP) || (state_q == ST_SHIFT_HI) ||
                  (state_q == ST_SHIFT_LO) || (state_q == ST_HOLD);
    allow_rise  = (state_q == ST_SETUP) || ((state_q == ST_SHIFT_LO) && (bit_cnt_q != '0));
    req_ready_c = (state_q == ST_IDLE);
    ss          = in_xfer ? ~ss_q : '1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    mosi        = in_xfer ? tx_q[0] : 1'b1;
`else
    mosi        = in_xfer ? tx_q[DATA_W-1] : 1'b1;
`endif
  end

  assign sck           = sck_int ^ SPI_MODE0[1];
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rx    = rx_q;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic [LW-1:0] len_q;
  always_ff @(posedge clock) begin
    if (reset)       len_q <= '0;
    else if (accept) len_q <= req_len_c;
  end
`endif

  always_comb begin
    tx_d        = tx_q;
    rx_d        = rx_q;
    ss_d        = ss_q;
    bit_cnt_d   = bit_cnt_q;
    rsp_valid_d = (state_q == ST_RESP) && !(rsp_valid_q && bus.rsp_ready);
    if (accept) begin
      rx_d      = '0;
      ss_d      = bus.req_ss;
      bit_cnt_d = req_len_c;
`ifdef SPI_MASTER_LSB_FIRST_EN
      tx_d      = bus.req_tx;
`else
      tx_d      = bus.req_tx << (LEN_MAX - req_len_c);
`endif
    end
    if (fall_pulse) begin
      bit_cnt_d = bit_cnt_q - LW'(1);
`ifdef SPI_MASTER_LSB_FIRST_EN
      tx_d      = {1'b0, tx_q[DATA_W-1:1]};
      rx_d      = {miso, rx_q[DATA_W-1:1]};
`else
      tx_d      = {tx_q[DATA_W-2:0], 1'b0};
      rx_d      = {rx_q[DATA_W-2:0], miso};
`endif
    end
`ifdef SPI_MASTER_LSB_FIRST_EN
    if ((state_q == ST_HOLD) && tick) rx_d = rx_q >> (LEN_MAX - len_q);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q        <= '0;
      rx_q        <= '0;
      ss_q        <= '0;
      bit_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ss_q        <= ss_d;
      bit_cnt_q   <= bit_cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a DIV=4 instance with selectable miso source
// and a DIV=1 instance in loopback.
module tb_spi_master;

  typedef struct {
    logic [63:0] rx;
    int          lat;
    int          rises;
    int          ss_bad;
    int          mosi_or;
    int          min_per;
    int          max_per;
    int          ss_and;
    logic [7:0]  ss_end;
    int          rdy_hi;
  } xfer_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic loop4  = 1'b1;
  logic force4 = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic       sck4, mosi4, miso4, sck1, mosi1, miso1;
  logic [7:0] ss4, ss1;

  spi_master_if #(.DATA_W(64), .SS_W(8)) if4 ();
  spi_master_if #(.DATA_W(64), .SS_W(8)) if1 ();

  assign miso4 = loop4 ? mosi4 : force4;
  assign miso1 = mosi1;

  spi_master #(.DATA_W(64), .SS_W(8), .DIV(4)) u_dut4 (
    .clock(clk), .reset(rst), .bus(if4),
    .sck(sck4), .ss(ss4), .mosi(mosi4), .miso(miso4)
  );

  spi_master #(.DATA_W(64), .SS_W(8), .DIV(1)) u_dut1 (
    .clock(clk), .reset(rst), .bus(if1),
    .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
  );

  always #5 clk = ~clk;

  task automatic drive_req(input bit sel, input logic v, input logic [63:0] tx,
                           input logic [6:0] len, input logic [7:0] ssm);
    if (sel) begin
      if1.req_valid = v; if1.req_tx = tx; if1.req_len = len; if1.req_ss = ssm;
    end else begin
      if4.req_valid = v; if4.req_tx = tx; if4.req_len = len; if4.req_ss = ssm;
    end
  endtask

  task automatic ack(input bit sel);
    if (sel) if1.rsp_ready = 1'b1; else if4.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (sel) if1.rsp_ready = 1'b0; else if4.rsp_ready = 1'b0;
  endtask

  // Issues one request, then watches the SPI pins each cycle until rsp_valid (bounded).
  task automatic do_xfer(input bit sel, input logic [63:0] tx, input logic [6:0] len,
                         input logic [7:0] ssm, input bit noise, output xfer_t r);
    bit         s, m, prev, rv, rdy;
    logic [7:0] ssv;
    int         last;
    r.rx = '0; r.lat = -1; r.rises = 0; r.ss_bad = 0; r.mosi_or = 0;
    r.min_per = 1000; r.max_per = 0; r.ss_and = 1; r.ss_end = '0; r.rdy_hi = 0;
    prev = 1'b0; last = -1;
    drive_req(sel, 1'b1, tx, len, ssm);
    @(posedge clk); #1;
    drive_req(sel, 1'b0, 64'h0, 7'd0, 8'h00);
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      s   = sel ? sck1 : sck4;
      m   = sel ? mosi1 : mosi4;
      ssv = sel ? ss1 : ss4;
      rv  = sel ? if1.rsp_valid : if4.rsp_valid;
      rdy = sel ? if1.req_ready : if4.req_ready;
      if (s && !prev) begin
        r.rises++;
        if (last >= 0) begin
          if (n - last < r.min_per) r.min_per = n - last;
          if (n - last > r.max_per) r.max_per = n - last;
        end
        last = n;
        if (ssv !== ~ssm) r.ss_bad++;
        if (m) r.mosi_or = 1;
      end
      prev = s;
      if (ssv !== 8'hFF) r.ss_and = 0;
      if (rv) begin
        r.lat    = n;
        r.ss_end = ssv;
        break;
      end
      if (rdy) r.rdy_hi++;
      if (noise) drive_req(sel, n[0], 64'hFFFF_FFFF_FFFF_FFFF, 7'd8, 8'h80);
    end
    if (noise) drive_req(sel, 1'b0, 64'h0, 7'd0, 8'h00);
    r.rx = sel ? if1.rsp_rx : if4.rsp_rx;
  endtask

  task automatic test_reset();
    checks++; if (sck4 !== 1'b0) begin failures++; $display("FAIL rst_sck: got %0b expected 0", sck4); end
    checks++; if (ss4 !== 8'hFF) begin failures++; $display("FAIL rst_ss: got %0h expected ff", ss4); end
    checks++; if (mosi4 !== 1'b1) begin failures++; $display("FAIL rst_mosi: got %0b expected 1", mosi4); end
    checks++; if (if4.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %0b expected 1", if4.req_ready); end
    checks++; if (if4.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %0b expected 0", if4.rsp_valid); end
    checks++; if (if4.rsp_rx !== 64'h0) begin failures++; $display("FAIL rst_rsp_rx: got %0h expected 0", if4.rsp_rx); end
  endtask

  task automatic test_loopback();
    xfer_t r;
    do_xfer(1'b0, 64'hA5, 7'd8, 8'h01, 1'b0, r);
    checks++; if (r.rx !== 64'hA5) begin failures++; $display("FAIL loop_rx: got %0h expected a5", r.rx); end
    checks++; if (r.lat !== 73) begin failures++; $display("FAIL loop_latency: got %0d expected 73", r.lat); end
    checks++; if (r.rises !== 8) begin failures++; $display("FAIL loop_rises: got %0d expected 8", r.rises); end
    checks++; if (r.ss_bad !== 0) begin failures++; $display("FAIL loop_ss_active: got %0d bad rises expected 0", r.ss_bad); end
    checks++; if (r.min_per !== 8 || r.max_per !== 8) begin failures++; $display("FAIL loop_period: got %0d..%0d expected 8", r.min_per, r.max_per); end
    checks++; if (r.ss_end !== 8'hFF) begin failures++; $display("FAIL loop_ss_end: got %0h expected ff", r.ss_end); end
    ack(1'b0);
    checks++; if (if4.req_ready !== 1'b1 || if4.rsp_valid !== 1'b0) begin failures++; $display("FAIL loop_after_ack: got ready=%0b valid=%0b expected 1/0", if4.req_ready, if4.rsp_valid); end
  endtask

  task automatic test_miso_high();
    xfer_t r;
    loop4 = 1'b0; force4 = 1'b1;
    do_xfer(1'b0, 64'h0, 7'd16, 8'h01, 1'b0, r);
    checks++; if (r.rx !== 64'hFFFF) begin failures++; $display("FAIL miso1_rx: got %0h expected ffff", r.rx); end
    checks++; if (r.mosi_or !== 0) begin failures++; $display("FAIL miso1_mosi_low: got %0d expected 0", r.mosi_or); end
    checks++; if (r.rises !== 16) begin failures++; $display("FAIL miso1_rises: got %0d expected 16", r.rises); end
    checks++; if (r.lat !== 137) begin failures++; $display("FAIL miso1_latency: got %0d expected 137", r.lat); end
    checks++; if (r.ss_end !== 8'hFF) begin failures++; $display("FAIL miso1_ss_end: got %0h expected ff", r.ss_end); end
    ack(1'b0);
    loop4 = 1'b1;
  endtask

  task automatic test_len_zero();
    xfer_t r;
    do_xfer(1'b0, 64'hFF, 7'd0, 8'h01, 1'b0, r);
    checks++; if (r.lat !== 1) begin failures++; $display("FAIL len0_latency: got %0d expected 1", r.lat); end
    checks++; if (r.rises !== 0) begin failures++; $display("FAIL len0_rises: got %0d expected 0", r.rises); end
    checks++; if (r.ss_and !== 1) begin failures++; $display("FAIL len0_ss_idle: got %0d expected 1", r.ss_and); end
    checks++; if (r.rx !== 64'h0) begin failures++; $display("FAIL len0_rx: got %0h expected 0", r.rx); end
    ack(1'b0);
  endtask

  task automatic test_back_to_back();
    xfer_t r;
    int    bad;
    do_xfer(1'b0, 64'h3C, 7'd8, 8'h04, 1'b1, r);
    checks++; if (r.rx !== 64'h3C) begin failures++; $display("FAIL b2b_first_rx: got %0h expected 3c", r.rx); end
    checks++; if (r.rdy_hi !== 0) begin failures++; $display("FAIL b2b_ready_busy: got %0d ready cycles expected 0", r.rdy_hi); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive_req(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd8, 8'h80);
      @(posedge clk); #1;
      if (if4.rsp_valid !== 1'b1 || if4.rsp_rx !== 64'h3C || if4.req_ready !== 1'b0) bad++;
    end
    drive_req(1'b0, 1'b0, 64'h0, 7'd0, 8'h00);
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_resp_hold: got %0d bad cycles expected 0", bad); end
    ack(1'b0);
    checks++; if (if4.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_no_stale_accept: got %0b expected 1", if4.req_ready); end
    do_xfer(1'b0, 64'h5A, 7'd8, 8'h80, 1'b0, r);
    checks++; if (r.rx !== 64'h5A) begin failures++; $display("FAIL b2b_second_rx: got %0h expected 5a", r.rx); end
    checks++; if (r.ss_bad !== 0) begin failures++; $display("FAIL b2b_second_ss: got %0d bad rises expected 0", r.ss_bad); end
    ack(1'b0);
  endtask

  task automatic test_reset_mid();
    xfer_t r;
    int    rises;
    bit    prev;
    rises = 0; prev = 1'b0;
    drive_req(1'b0, 1'b1, 64'hDEAD_BEEF, 7'd32, 8'h01);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 64'h0, 7'd0, 8'h00);
    for (int n = 0; n < 1000 && rises < 5; n++) begin
      @(posedge clk); #1;
      if (sck4 && !prev) rises++;
      prev = sck4;
    end
    checks++; if (rises !== 5 || sck4 !== 1'b1) begin failures++; $display("FAIL mid_reach_bit5: got rises=%0d sck=%0b expected 5/1", rises, sck4); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (sck4 !== 1'b0) begin failures++; $display("FAIL mid_sck: got %0b expected 0", sck4); end
    checks++; if (ss4 !== 8'hFF) begin failures++; $display("FAIL mid_ss: got %0h expected ff", ss4); end
    checks++; if (mosi4 !== 1'b1) begin failures++; $display("FAIL mid_mosi: got %0b expected 1", mosi4); end
    checks++; if (if4.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid: got %0b expected 0", if4.rsp_valid); end
    checks++; if (if4.req_ready !== 1'b1) begin failures++; $display("FAIL mid_req_ready: got %0b expected 1", if4.req_ready); end
    rst = 1'b0;
    do_xfer(1'b0, 64'h96, 7'd8, 8'h02, 1'b0, r);
    checks++; if (r.rx !== 64'h96) begin failures++; $display("FAIL mid_retry_rx: got %0h expected 96", r.rx); end
    checks++; if (r.lat !== 73) begin failures++; $display("FAIL mid_retry_latency: got %0d expected 73", r.lat); end
    checks++; if (r.rises !== 8) begin failures++; $display("FAIL mid_retry_rises: got %0d expected 8", r.rises); end
    ack(1'b0);
  endtask

  task automatic test_div1();
    xfer_t r;
    do_xfer(1'b1, 64'h0123_4567_89AB_CDEF, 7'd64, 8'h10, 1'b0, r);
    checks++; if (r.rx !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL div1_rx: got %0h expected 123456789abcdef", r.rx); end
    checks++; if (r.rises !== 64) begin failures++; $display("FAIL div1_rises: got %0d expected 64", r.rises); end
    checks++; if (r.min_per !== 2 || r.max_per !== 2) begin failures++; $display("FAIL div1_period: got %0d..%0d expected 2", r.min_per, r.max_per); end
    checks++; if (r.lat !== 131) begin failures++; $display("FAIL div1_latency: got %0d expected 131", r.lat); end
    checks++; if (r.ss_bad !== 0) begin failures++; $display("FAIL div1_ss: got %0d bad rises expected 0", r.ss_bad); end
    ack(1'b1);
    do_xfer(1'b1, 64'hFEDC_BA98_7654_3210, 7'd100, 8'h01, 1'b0, r);
    checks++; if (r.rises !== 64) begin failures++; $display("FAIL clamp_rises: got %0d expected 64", r.rises); end
    checks++; if (r.rx !== 64'hFEDC_BA98_7654_3210) begin failures++; $display("FAIL clamp_rx: got %0h expected fedcba9876543210", r.rx); end
    checks++; if (r.lat !== 131) begin failures++; $display("FAIL clamp_latency: got %0d expected 131", r.lat); end
    ack(1'b1);
  endtask

  initial begin
    drive_req(1'b0, 1'b0, 64'h0, 7'd0, 8'h00);
    drive_req(1'b1, 1'b0, 64'h0, 7'd0, 8'h00);
    if4.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_loopback();
    test_miso_high();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
